// File: rtl/alu_seq_exec.sv
// alu_seq_exec: EX-stage ALU driven by the 4-bit ALU control lines.
// Logical/arithmetic/compare ops finish in one cycle; shifts run one bit
// per cycle unless ALU_BARREL_SHIFT_EN is defined, in which case a
// single-cycle barrel shifter is used and the SHIFT state is never entered.
module alu_seq_exec #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUctrl_lines,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            zero
);

  localparam logic [1:0] IDLE  = 2'd0;
`ifndef ALU_BARREL_SHIFT_EN
  localparam logic [1:0] SHIFT = 2'd1;
`endif
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;

  logic [1:0]         state;
  logic [XLEN-1:0]    res;
  logic               br;
  logic [XLEN-1:0]    alu_res;
  logic               alu_br;
  logic [SHAMT_W-1:0] shamt;
  logic               lt_s, lt_u, eq;

  assign shamt = op_b[SHAMT_W-1:0];
  assign lt_s  = $signed(op_a) < $signed(op_b);
  assign lt_u  = op_a < op_b;
  assign eq    = op_a == op_b;

  // Single-cycle datapath evaluated on the inputs at acceptance time.
  // In the iterative build a shift just loads op_a as the working value.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (ALUctrl_lines)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_a - op_b;
      4'b0011: alu_res = op_a ^ op_b;
      4'b0110: alu_res = op_a | op_b;
      4'b0111: alu_res = op_a & op_b;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
`else
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
`endif
      4'b1000: begin alu_res = XLEN'(lt_s);  alu_br = lt_s;  end
      4'b1001: begin alu_res = XLEN'(!lt_s); alu_br = !lt_s; end
      4'b1010: begin alu_res = XLEN'(lt_u);  alu_br = lt_u;  end
      4'b1011: begin alu_res = XLEN'(!lt_u); alu_br = !lt_u; end
      4'b1100: begin alu_res = XLEN'(eq);    alu_br = eq;    end
      4'b1101: begin alu_res = XLEN'(!eq);   alu_br = !eq;   end
      4'b1110: alu_res = XLEN'(lt_s);
      4'b1111: alu_res = XLEN'(lt_u);
      default: alu_res = '0;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         op_q;
  logic [XLEN-1:0]    res_step;
  logic               is_shift;

  assign is_shift = (ALUctrl_lines == OP_SLL) || (ALUctrl_lines == OP_SRL) ||
                    (ALUctrl_lines == OP_SRA);

  // One-bit step of the working register in the latched shift type.
  always_comb begin
    res_step = res;
    case (op_q)
      OP_SLL:  res_step = {res[XLEN-2:0], 1'b0};
      OP_SRL:  res_step = {1'b0, res[XLEN-1:1]};
      OP_SRA:  res_step = {res[XLEN-1], res[XLEN-1:1]};
      default: res_step = res;
    endcase
  end
`endif

  // Control FSM plus result/flag registers; reset wins in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      res   <= '0;
      br    <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      cnt   <= '0;
      op_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          res <= alu_res;
          br  <= alu_br;
`ifdef ALU_BARREL_SHIFT_EN
          state <= DONE;
`else
          op_q <= ALUctrl_lines;
          cnt  <= shamt;
          if (is_shift && shamt != '0) state <= SHIFT;
          else                         state <= DONE;
`endif
        end
`ifndef ALU_BARREL_SHIFT_EN
        SHIFT: begin
          res <= res_step;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) state <= DONE;
        end
`endif
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign result       = res;
  assign branch_taken = br;
  assign zero         = (res == '0);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: driver pushes expected responses,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_alu_seq_exec;
  localparam int XLEN = 32;

  logic            clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]      ctrl;
  logic [XLEN-1:0] op_a, op_b, result;
  logic            branch_taken, zero;

  alu_seq_exec #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctrl_lines(ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .branch_taken(branch_taken),
    .zero(zero)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    logic            br;
    int              lat;
    int              acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0, passes = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   force_rdy = 1;
  bit   mon_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [XLEN-1:0] got,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model straight from the operation table.
  function automatic logic [XLEN:0] model(input logic [3:0] op,
                                          input logic [XLEN-1:0] a, b);
    int unsigned s = b % XLEN;
    logic [XLEN-1:0] r = '0;
    logic t = 0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << s;
      3:  r = a ^ b;
      4:  r = a >> s;
      5:  r = $signed(a) >>> s;
      6:  r = a | b;
      7:  r = a & b;
      8:  begin t = $signed(a) <  $signed(b); r = {31'b0, t}; end
      9:  begin t = $signed(a) >= $signed(b); r = {31'b0, t}; end
      10: begin t = a <  b; r = {31'b0, t}; end
      11: begin t = a >= b; r = {31'b0, t}; end
      12: begin t = a == b; r = {31'b0, t}; end
      13: begin t = a != b; r = {31'b0, t}; end
      14: r = {31'b0, $signed(a) < $signed(b)};
      15: r = {31'b0, a < b};
      default: r = '0;
    endcase
    return {t, r};
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [XLEN-1:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (op == 2 || op == 4 || op == 5) return 1 + int'(b % XLEN);
    return 1;
`endif
  endfunction

  // Present one op and wait for acceptance, then scramble the inputs.
  task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a, b,
                      input logic [XLEN-1:0] er, input logic eb);
    exp_t e;
    bit   done = 0;
    ctrl = op; op_a = a; op_b = b; in_valid = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = er; e.br = eb; e.lat = lat_of(op, b); e.acc = cyc;
        q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: op %0d never accepted", op);
    end
    in_valid = 0; ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic send_m(input logic [3:0] op, input logic [XLEN-1:0] a, b);
    logic [XLEN:0] m = model(op, a, b);
    send(op, a, b, m[XLEN-1:0], m[XLEN]);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (q.size() != 0 && n < max_cyc) begin @(posedge clk); n++; end
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  // Random backpressure when not under directed control.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (!force_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare presented output with the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL stale_out: out_valid with nothing in flight, result 0x%08h", result);
        end else begin
          chk("result", result, q[0].res);
          chk("branch_taken", {31'b0, branch_taken}, {31'b0, q[0].br});
          chk("zero", {31'b0, zero}, {31'b0, q[0].res == 0});
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - q[0].acc, q[0].lat);
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 0; in_valid = 0; ctrl = 0; op_a = 0; op_b = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", {31'b0, zero}, 1);
    chk("rst_branch", {31'b0, branch_taken}, 0);
    mon_en = 1;
    @(posedge clk); #1;

    // Directed operations with hand-derived expectations.
    force_rdy = 1; out_ready = 1;
    send(4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0);
    send(4'd1, 32'd5, 32'd5, 32'h0, 0);
    send(4'd5, 32'h80000000, 32'd4, 32'hF8000000, 0);
    send(4'd4, 32'h80000000, 32'd4, 32'h08000000, 0);
    send(4'd2, 32'h12345678, 32'd0, 32'h12345678, 0);
    send(4'd2, 32'h00000001, 32'd31, 32'h80000000, 0);
    send(4'd8, 32'hFFFFFFFF, 32'd1, 32'h1, 1);
    send(4'd10, 32'hFFFFFFFF, 32'd1, 32'h0, 0);
    send(4'd15, 32'hFFFFFFFF, 32'd1, 32'h0, 0);
    send(4'd12, 32'h1234, 32'h1234, 32'h1, 1);
    send(4'd13, 32'h1234, 32'h1234, 32'h0, 0);
    drain(100);

    // Backpressure: hold the XOR result, a new op must wait.
    out_ready = 0;
    send(4'd3, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 0);
    ctrl = 4'd0; op_a = 32'd1; op_b = 32'd2; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 0);
      chk("bp_out_valid", {31'b0, out_valid}, 1);
    end
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    chk("bp_in_ready_hs", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    send(4'd0, 32'd1, 32'd2, 32'd3, 0);
    drain(100);

    // Reset in the middle of a long shift.
    send(4'd2, 32'h1, 32'd20, 32'h00100000, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    q.delete(); seen = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_branch", {31'b0, branch_taken}, 0);
    repeat (40) @(posedge clk);
    #1;

    // Random stream with random in_valid gaps and backpressure.
    force_rdy = 0;
    for (int n = 0; n < 200; n++) begin
      logic [3:0]      op = 4'($urandom);
      logic [XLEN-1:0] a = $urandom, b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 1) == 0) b = b & 32'h1F;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_m(op, a, b);
    end
    force_rdy = 1; out_ready = 1;
    drain(200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
